// File: rtl/bitwise_logic_unit.sv
// Registered bitwise AND/OR/XOR/XNOR unit with valid/ready handshakes and a chaining accumulator.
// Optional registered parity output is enabled by defining BWLU_PARITY_EN.
module bitwise_logic_unit #(
    parameter int unsigned      WIDTH     = 20,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [1:0]       op,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             zero
`ifdef BWLU_PARITY_EN
    ,
    output logic             parity
`endif
);

    typedef enum logic [1:0] {
        OpAnd  = 2'b00,
        OpOr   = 2'b01,
        OpXor  = 2'b10,
        OpXnor = 2'b11
    } op_e;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;
    logic             xfer_in;
    logic             xfer_out;

    assign in_ready = !out_valid_q || out_ready;
    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid_q && out_ready;
    assign op_a     = acc ? acc_q : i0;

    always_comb begin
        result = '0;
        unique case (op_e'(op))
            OpAnd:  result = op_a & i1;
            OpOr:   result = op_a | i1;
            OpXor:  result = op_a ^ i1;
            OpXnor: result = ~(op_a ^ i1);
            default: result = '0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        s_d         = s_q;
        zero_d      = zero_q;
        acc_d       = acc_q;
        if (xfer_in) begin
            // A new result may replace one being consumed in the same cycle: no bubble.
            out_valid_d = 1'b1;
            s_d         = result;
            zero_d      = (result == '0);
            acc_d       = result;
        end else if (xfer_out) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            zero_q      <= 1'b1;
            acc_q       <= ACC_RESET;
        end else begin
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            zero_q      <= zero_d;
            acc_q       <= acc_d;
        end
    end

`ifdef BWLU_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (xfer_in) begin
            parity_d = ^result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit: stimulus pushes hand-computed results into a queue,
// a monitor pops and compares on every output transfer.
module tb_bitwise_logic_unit;

    localparam int unsigned WIDTH = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [1:0]       op;
    logic             acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             zero;
`ifdef BWLU_PARITY_EN
    logic             parity;
`endif

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             z;
        logic             p;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bitwise_logic_unit #(
        .WIDTH    (WIDTH),
        .ACC_RESET(20'h00000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .i0       (i0),
        .i1       (i1),
        .op       (op),
        .acc      (acc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .zero     (zero)
`ifdef BWLU_PARITY_EN
        ,
        .parity   (parity)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on every output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got s=0x%0h expected no output", s);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_s", 64'(s), 64'(e.s));
                    chk("out_zero", 64'(zero), 64'(e.z));
`ifdef BWLU_PARITY_EN
                    chk("out_parity", 64'(parity), 64'(e.p));
`endif
                end
            end
        end
    end

    // Drives one operand set and waits (bounded) for acceptance; returns stall cycles.
    task automatic send(input logic [1:0] o, input logic a, input logic [WIDTH-1:0] x0,
                        input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] es,
                        input logic ez, input logic ep, output int stalls);
        exp_t e;
        bit   ok = 1'b0;
        stalls   = 0;
        in_valid = 1'b1;
        op       = o;
        acc      = a;
        i0       = x0;
        i1       = x1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
        end else begin
            @(posedge clk);
            e.s = es;
            e.z = ez;
            e.p = ep;
            exp_q.push_back(e);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        acc      = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        rst       = 1'b1;
        in_valid  = 1'b0;
        i0        = '0;
        i1        = '0;
        op        = 2'b00;
        acc       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s", 64'(s), 64'h0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef BWLU_PARITY_EN
        chk("rst_parity", 64'(parity), 64'd0);
`endif
        @(posedge clk);
        #1;

        // Single XOR with zero operand
        send(2'b10, 1'b0, 20'h0005F, 20'h00000, 20'h0005F, 1'b0, 1'b0, st);
        idle(2);

        // Back-to-back XOR / XNOR both yielding zero, no bubble between
        send(2'b10, 1'b0, 20'hC0003, 20'hC0003, 20'h00000, 1'b1, 1'b0, st);
        send(2'b11, 1'b0, 20'hFFFFF, 20'h00000, 20'h00000, 1'b1, 1'b0, st);
        chk("b2b_stall", 64'(st), 64'd0);
        idle(2);

        // Accumulator chain
        send(2'b01, 1'b0, 20'h0F0F0, 20'h00001, 20'h0F0F1, 1'b0, 1'b1, st);
        send(2'b00, 1'b1, 20'h12345, 20'h000F1, 20'h000F1, 1'b0, 1'b1, st);
        send(2'b10, 1'b1, 20'h00000, 20'hFFFFF, 20'hFFF0E, 1'b0, 1'b1, st);
        chk("chain_stall", 64'(st), 64'd0);
        idle(2);

        // Backpressure: result held, new operands refused for 3 cycles
        out_ready = 1'b0;
        send(2'b00, 1'b0, 20'hAAAAA, 20'hFFFFF, 20'hAAAAA, 1'b0, 1'b0, st);
        in_valid = 1'b1;
        op       = 2'b01;
        acc      = 1'b1;
        i0       = 20'h55555;
        i1       = 20'h00005;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_s_hold", 64'(s), 64'hAAAAA);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        // acc_reg still AAAAA, so OR 00005 gives AAAAF
        send(2'b01, 1'b1, 20'h55555, 20'h00005, 20'hAAAAF, 1'b0, 1'b0, st);
        chk("bp_release_stall", 64'(st), 64'd0);
        idle(2);

        // Reset dominates a concurrent transfer in
        rst      = 1'b1;
        in_valid = 1'b1;
        op       = 2'b10;
        acc      = 1'b0;
        i0       = 20'hFFFFF;
        i1       = 20'h00000;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstx_out_valid", 64'(out_valid), 64'd0);
        chk("rstx_s", 64'(s), 64'h0);
        chk("rstx_zero", 64'(zero), 64'd1);
        @(posedge clk);
        #1;
        // acc_reg must be ACC_RESET (0), not FFFFF
        send(2'b01, 1'b1, 20'hFFFFF, 20'h00000, 20'h00000, 1'b1, 1'b0, st);
        idle(3);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
